background_control_pipeline: RTL and testbench

BACKGROUND_CONTROL_PIPELINE -- requirements
Module: background_control_pipeline

---
 rtl/background_control_pipeline_pkg.sv | 21 ++
 rtl/background_control_pipeline_serial_shift_word.sv | 41 ++++
 rtl/background_control_pipeline.sv | 177 +++++++++++++++++
 tb/tb_background_control_pipeline.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/background_control_pipeline_pkg.sv
// Shared widths and helpers for the background tile fetch pipeline.
package background_control_pipeline_pkg;

    localparam int SLOT_LEN = 8;
    localparam int COL_W    = 8;
    localparam int WORD_W   = 8;
    localparam int PAN_W    = 3;
    localparam int PH_W     = $clog2(SLOT_LEN);
    localparam int NSTAGE   = 6;

    typedef logic [WORD_W-1:0] word_t;

    function automatic logic pal_lookup(
        input logic [3:0] pal,
        input logic       hi,
        input logic       lo
    );
        return pal[{hi, lo}];
    endfunction

endpackage

// File: rtl/background_control_pipeline_serial_shift_word.sv
// 8-bit LSB-first serializer / deserializer shared by every serial bus.
module serial_shift_word
    import background_control_pipeline_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr_i,
    input  logic  load_i,
    input  logic  shift_i,
    input  word_t load_val_i,
    input  logic  ser_i,
    output logic  ser_o,
    output word_t next_o
);

    word_t word_q;
    word_t word_d;

    always_comb begin
        word_d = word_q;
        if (clr_i) begin
            word_d = '0;
        end else if (load_i) begin
            word_d = load_val_i;
        end else if (shift_i) begin
            word_d = {ser_i, word_q[WORD_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign ser_o  = word_q[0];
    assign next_o = {ser_i, word_q[WORD_W-1:1]};

endmodule

// File: rtl/background_control_pipeline.sv
// Background line fetch: column address -> char/palette -> tile planes -> pixels.
module background_control_pipeline
    import background_control_pipeline_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lineStarting,
    input  logic [PAN_W-1:0] panOffset,
    output logic             charAddrOut,
    output logic             palAddrOut,
    input  logic             charDataIn,
    input  logic             palDataIn,
    output logic             tileLowAddrOut,
    output logic             tileHighAddrOut,
    input  logic             tileLowDataIn,
    input  logic             tileHighDataIn,
    output logic             pixelOut
);

    logic              run_q, run_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [NSTAGE-1:0] vld_q, vld_d;
    logic [PAN_W-1:0]  pan_q, pan_d;
    logic [3:0]        pal1_q, pal1_d, pal2_q, pal2_d, pal3_q, pal3_d;
    logic [3:0]        palc_q, palc_d, paln_q, paln_d;
    word_t             lo_q, lo_d, hi_q, hi_d;
    logic [2*WORD_W-1:0] wlo_q, wlo_d, whi_q, whi_d;
    logic              pix_q, pix_d;

    logic       adv, bnd;
    logic       cad_ser, tad_ser;
    word_t      chr_nx, pal_nx, tlo_nx, thi_nx;
    word_t      cad_unused, tad_unused;
    logic [3:0] ser_unused;
    logic [3:0] pal_hi_unused;
    logic [PH_W:0] idx;
    logic [3:0] sel_pal;

    assign adv = run_q & ~lineStarting;
    assign bnd = adv & (ph_q == PH_W'(SLOT_LEN - 1));
    assign pal_hi_unused = pal_nx[7:4];

    serial_shift_word u_col_addr (
        .clk(clk), .rst_n(rst_n), .clr_i(1'b0),
        .load_i(lineStarting | bnd), .shift_i(adv),
        .load_val_i(lineStarting ? '0 : col_q + COL_W'(1)),
        .ser_i(1'b0), .ser_o(cad_ser), .next_o(cad_unused)
    );

    serial_shift_word u_chr_data (
        .clk(clk), .rst_n(rst_n), .clr_i(lineStarting),
        .load_i(1'b0), .shift_i(adv), .load_val_i('0),
        .ser_i(charDataIn), .ser_o(ser_unused[0]), .next_o(chr_nx)
    );

    serial_shift_word u_pal_data (
        .clk(clk), .rst_n(rst_n), .clr_i(lineStarting),
        .load_i(1'b0), .shift_i(adv), .load_val_i('0),
        .ser_i(palDataIn), .ser_o(ser_unused[1]), .next_o(pal_nx)
    );

    // Char code of the column fetched last slot becomes this slot's tile address.
    serial_shift_word u_tile_addr (
        .clk(clk), .rst_n(rst_n), .clr_i(lineStarting),
        .load_i(bnd), .shift_i(adv),
        .load_val_i(vld_q[1] ? chr_nx : '0),
        .ser_i(1'b0), .ser_o(tad_ser), .next_o(tad_unused)
    );

    serial_shift_word u_tile_lo (
        .clk(clk), .rst_n(rst_n), .clr_i(lineStarting),
        .load_i(1'b0), .shift_i(adv), .load_val_i('0),
        .ser_i(tileLowDataIn), .ser_o(ser_unused[2]), .next_o(tlo_nx)
    );

    serial_shift_word u_tile_hi (
        .clk(clk), .rst_n(rst_n), .clr_i(lineStarting),
        .load_i(1'b0), .shift_i(adv), .load_val_i('0),
        .ser_i(tileHighDataIn), .ser_o(ser_unused[3]), .next_o(thi_nx)
    );

    always_comb begin
        run_d  = run_q;
        ph_d   = ph_q;
        col_d  = col_q;
        vld_d  = vld_q;
        pan_d  = pan_q;
        pal1_d = pal1_q;
        pal2_d = pal2_q;
        pal3_d = pal3_q;
        palc_d = palc_q;
        paln_d = paln_q;
        lo_d   = lo_q;
        hi_d   = hi_q;
        wlo_d  = wlo_q;
        whi_d  = whi_q;
        if (lineStarting) begin
            run_d  = 1'b1;
            ph_d   = '0;
            col_d  = '0;
            vld_d  = NSTAGE'(1);
            pan_d  = panOffset;
            pal1_d = '0;
            pal2_d = '0;
            pal3_d = '0;
            palc_d = '0;
            paln_d = '0;
            lo_d   = '0;
            hi_d   = '0;
            wlo_d  = '0;
            whi_d  = '0;
        end else if (run_q) begin
            ph_d = ph_q + PH_W'(1);
            if (bnd) begin
                col_d  = col_q + COL_W'(1);
                vld_d  = {vld_q[NSTAGE-2:0], 1'b1};
                pal1_d = vld_q[1] ? pal_nx[3:0] : '0;
                pal2_d = pal1_q;
                pal3_d = pal2_q;
                lo_d   = tlo_nx;
                hi_d   = thi_nx;
                // Window spans this column and the next so pan can borrow pixels.
                wlo_d  = {tlo_nx, lo_q};
                whi_d  = {thi_nx, hi_q};
                palc_d = pal3_q;
                paln_d = pal2_q;
            end
        end
        idx     = {1'b0, ph_d} + {1'b0, pan_d};
        sel_pal = idx[PH_W] ? paln_d : palc_d;
        pix_d   = vld_d[NSTAGE-1] & pal_lookup(sel_pal, whi_d[idx], wlo_d[idx]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= 1'b0;
            ph_q   <= '0;
            col_q  <= '0;
            vld_q  <= '0;
            pan_q  <= '0;
            pal1_q <= '0;
            pal2_q <= '0;
            pal3_q <= '0;
            palc_q <= '0;
            paln_q <= '0;
            lo_q   <= '0;
            hi_q   <= '0;
            wlo_q  <= '0;
            whi_q  <= '0;
            pix_q  <= 1'b0;
        end else begin
            run_q  <= run_d;
            ph_q   <= ph_d;
            col_q  <= col_d;
            vld_q  <= vld_d;
            pan_q  <= pan_d;
            pal1_q <= pal1_d;
            pal2_q <= pal2_d;
            pal3_q <= pal3_d;
            palc_q <= palc_d;
            paln_q <= paln_d;
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            wlo_q  <= wlo_d;
            whi_q  <= whi_d;
            pix_q  <= pix_d;
        end
    end

    assign charAddrOut     = cad_ser;
    assign palAddrOut      = cad_ser;
    assign tileLowAddrOut  = tad_ser;
    assign tileHighAddrOut = tad_ser;
    assign pixelOut        = pix_q;

endmodule

// File: tb/tb_background_control_pipeline.sv
// Directed bench for background_control_pipeline.
module tb_background_control_pipeline;

    localparam int NSLOT = 300;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lineStarting = 1'b0;
    logic [2:0] panOffset = '0;
    logic       charAddrOut, palAddrOut;
    logic       charDataIn = 1'b0, palDataIn = 1'b0;
    logic       tileLowAddrOut, tileHighAddrOut;
    logic       tileLowDataIn = 1'b0, tileHighDataIn = 1'b0;
    logic       pixelOut;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] chr_a[8];
    logic [7:0] pal_a[8];
    logic [7:0] lo_a[8];
    logic [7:0] hi_a[8];

    logic [7:0] cadr_w[NSLOT];
    logic [7:0] padr_w[NSLOT];
    logic [7:0] tlad_w[NSLOT];
    logic [7:0] thad_w[NSLOT];
    logic [7:0] pix_w[NSLOT];

    background_control_pipeline dut (
        .clk(clk),
        .rst_n(rst_n),
        .lineStarting(lineStarting),
        .panOffset(panOffset),
        .charAddrOut(charAddrOut),
        .palAddrOut(palAddrOut),
        .charDataIn(charDataIn),
        .palDataIn(palDataIn),
        .tileLowAddrOut(tileLowAddrOut),
        .tileHighAddrOut(tileHighAddrOut),
        .tileLowDataIn(tileLowDataIn),
        .tileHighDataIn(tileHighDataIn),
        .pixelOut(pixelOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] col_chr(input int c);
        return (c >= 0 && c < 8) ? chr_a[c] : 8'h00;
    endfunction
    function automatic logic [7:0] col_pal(input int c);
        return (c >= 0 && c < 8) ? pal_a[c] : 8'h00;
    endfunction
    function automatic logic [7:0] col_lo(input int c);
        return (c >= 0 && c < 8) ? lo_a[c] : 8'h00;
    endfunction
    function automatic logic [7:0] col_hi(input int c);
        return (c >= 0 && c < 8) ? hi_a[c] : 8'h00;
    endfunction

    function automatic logic [7:0] exp_pix(input int c, input int pan);
        logic [7:0] r, pv, lv, hv;
        r = '0;
        for (int p = 0; p < 8; p++) begin
            int i, cc, b;
            i  = p + pan;
            cc = (i < 8) ? c : c + 1;
            b  = i % 8;
            pv = col_pal(cc);
            lv = col_lo(cc);
            hv = col_hi(cc);
            r[p] = pv[{hv[b], lv[b]}];
        end
        return r;
    endfunction

    task automatic set_col(input int c, input logic [7:0] ch,
                           input logic [7:0] pl, input logic [7:0] lo,
                           input logic [7:0] hi);
        chr_a[c] = ch;
        pal_a[c] = pl;
        lo_a[c]  = lo;
        hi_a[c]  = hi;
    endtask

    task automatic clear_cols();
        for (int c = 0; c < 8; c++) set_col(c, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    task automatic start_line(input logic [2:0] pan);
        @(negedge clk);
        lineStarting = 1'b1;
        panOffset = pan;
        cyc = 0;
        for (int s = 0; s < NSLOT; s++) begin
            cadr_w[s] = '0;
            padr_w[s] = '0;
            tlad_w[s] = '0;
            thad_w[s] = '0;
            pix_w[s]  = '0;
        end
    endtask

    task automatic step();
        int s, p;
        logic [7:0] w;
        @(negedge clk);
        lineStarting = 1'b0;
        s = cyc / 8;
        p = cyc % 8;
        if (s < NSLOT) begin
            cadr_w[s][p] = charAddrOut;
            padr_w[s][p] = palAddrOut;
            tlad_w[s][p] = tileLowAddrOut;
            thad_w[s][p] = tileHighAddrOut;
            pix_w[s][p]  = pixelOut;
        end
        w = (s >= 1) ? col_chr(s - 1) : 8'($urandom);
        charDataIn = w[p];
        w = (s >= 1) ? col_pal(s - 1) : 8'($urandom);
        palDataIn = w[p];
        w = (s >= 3) ? col_lo(s - 3) : 8'($urandom);
        tileLowDataIn = w[p];
        w = (s >= 3) ? col_hi(s - 3) : 8'($urandom);
        tileHighDataIn = w[p];
        cyc++;
    endtask

    task automatic run_slots(input int n);
        repeat (n * 8) step();
    endtask

    task automatic idle_check(input string tag, input int n);
        logic acc;
        acc = 1'b0;
        repeat (n) begin
            @(negedge clk);
            acc = acc | charAddrOut | palAddrOut | tileLowAddrOut
                | tileHighAddrOut | pixelOut;
            charDataIn     = 1'($urandom);
            palDataIn      = 1'($urandom);
            tileLowDataIn  = 1'($urandom);
            tileHighDataIn = 1'($urandom);
        end
        check(tag, 32'(acc), 32'd0);
    endtask

    initial begin
        logic [7:0] acc8;
        clear_cols();
        #3;
        check("rst_outs", {charAddrOut, palAddrOut, tileLowAddrOut,
                           tileHighAddrOut, pixelOut}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_check("idle_pre_line", 24);

        // Pan 0: address sequencing, char->tile address, basic pixels
        set_col(0, 8'hA5, 8'h02, 8'hFF, 8'h00);
        set_col(1, 8'h3C, 8'h09, 8'h0F, 8'h33);
        start_line(3'd0);
        run_slots(258);
        check("cadr_s0", cadr_w[0], 8'h00);
        check("cadr_s3", cadr_w[3], 8'h03);
        check("padr_s3", padr_w[3], 8'h03);
        check("cadr_s255", cadr_w[255], 8'hFF);
        check("cadr_s256", cadr_w[256], 8'h00);
        check("cadr_s257", cadr_w[257], 8'h01);
        check("tadr_s1", tlad_w[1], 8'h00);
        check("tladr_s2", tlad_w[2], 8'hA5);
        check("thadr_s2", thad_w[2], 8'hA5);
        check("tladr_s3", tlad_w[3], 8'h3C);
        acc8 = pix_w[0] | pix_w[1] | pix_w[2] | pix_w[3] | pix_w[4];
        check("pix_s0_4", acc8, 8'h00);
        check("pix_s5_pan0", pix_w[5], 8'hFF);
        check("pix_s6_pan0", pix_w[6], 8'hC3);

        // Palette zero masks the same planes
        set_col(0, 8'hA5, 8'h00, 8'hFF, 8'h00);
        start_line(3'd0);
        run_slots(6);
        check("pix_s5_pal0", pix_w[5], 8'h00);

        // Pan 3 borrows three pixels from column 1
        clear_cols();
        set_col(0, 8'h11, 8'h01, 8'h00, 8'h00);
        set_col(1, 8'h22, 8'h00, 8'hFF, 8'h00);
        start_line(3'd3);
        run_slots(6);
        check("pix_s5_pan3", pix_w[5], 8'h1F);

        // Mixed planes and palettes under pan 5
        set_col(0, 8'h5A, 8'h0E, 8'hF0, 8'hCC);
        set_col(1, 8'h81, 8'h06, 8'h55, 8'h0F);
        set_col(2, 8'h7E, 8'hF9, 8'hAA, 8'h3C);
        set_col(3, 8'h01, 8'h0B, 8'h33, 8'hF0);
        set_col(4, 8'hFE, 8'h07, 8'hC3, 8'h18);
        start_line(3'd5);
        run_slots(10);
        for (int s = 5; s < 10; s++)
            check($sformatf("pix_pan5_s%0d", s), pix_w[s], exp_pix(s - 5, 5));

        // Restart in slot 7 flushes the pipe
        start_line(3'd0);
        run_slots(7);
        repeat (3) step();
        start_line(3'd0);
        run_slots(6);
        acc8 = pix_w[0] | pix_w[1] | pix_w[2] | pix_w[3] | pix_w[4];
        check("restart_pix0_4", acc8, 8'h00);
        check("restart_cadr0", cadr_w[0], 8'h00);
        check("restart_cadr1", cadr_w[1], 8'h01);
        check("restart_pix5", pix_w[5], exp_pix(0, 0));

        // Reset mid-line
        start_line(3'd2);
        run_slots(6);
        repeat (2) step();
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid", {charAddrOut, palAddrOut, tileLowAddrOut,
                          tileHighAddrOut, pixelOut}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_check("idle_post_rst", 30);
        start_line(3'd0);
        run_slots(3);
        check("post_rst_cadr1", cadr_w[1], 8'h01);
        check("post_rst_tadr2", tlad_w[2], chr_a[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end

endmodule
